reg_writeback: RTL and testbench

- Writeback stage directly upstream of the register file's write port.
- Accepts one retiring instruction at a time: either an ALU result or a load.
- For loads, waits for memory read data, extracts the byte/halfword lane, and sign- or zero-extends it.
- Drives write_reg_addr / write_reg_data / do_reg_write as a one-cycle registered commit, and flags misalignment and memory timeout.

---
 rtl/tinisoc_pkg.sv | 39 +++
 rtl/reg_writeback_load_extract.sv | 41 ++++
 rtl/reg_writeback.sv | 194 +++++++++++++++++++
 tb/tb_reg_writeback.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinisoc_pkg.sv
// -----------------------------------------------------------------------------
// tinisoc_pkg
//   Shared encodings for the writeback path: load size codes, error codes,
//   writeback FSM state encoding, and a small alignment helper.
// -----------------------------------------------------------------------------
package tinisoc_pkg;

    // Load access size as presented by the memory stage.
    typedef enum logic [1:0] {
        LS_BYTE = 2'b00,
        LS_HALF = 2'b01,
        LS_WORD = 2'b10,
        LS_RSVD = 2'b11
    } load_size_e;

    // Error code reported on wb_err_code; ERR_NONE only ever appears after reset.
    typedef enum logic [1:0] {
        ERR_NONE     = 2'b00,
        ERR_MISALIGN = 2'b01,
        ERR_TIMEOUT  = 2'b10,
        ERR_SIZE     = 2'b11
    } wb_err_e;

    // Writeback controller states.
    typedef enum logic [1:0] {
        ST_IDLE     = 2'b00,
        ST_WAIT_MEM = 2'b01,
        ST_COMMIT   = 2'b10
    } wb_state_e;

    // A halfword must sit on an even address, a word on a multiple of four.
    // Bytes are always aligned.
    function automatic logic is_misaligned(input load_size_e size,
                                           input logic [1:0] offset);
        return ((size == LS_HALF) && offset[0]) ||
               ((size == LS_WORD) && (offset != 2'b00));
    endfunction

endpackage

// File: rtl/reg_writeback_load_extract.sv
// -----------------------------------------------------------------------------
// load_extract
//   Combinational lane select and sign/zero extension for little-endian loads.
//
//   i_rdata   in  DataSize  raw memory read word
//   i_size    in  2         LS_BYTE / LS_HALF / LS_WORD (LS_RSVD passes word)
//   i_signed  in  1         replicate MSB of the extracted field when set
//   i_offset  in  2         address[1:0] of the load
//   o_data    out DataSize  extended load value
// -----------------------------------------------------------------------------
module load_extract
    import tinisoc_pkg::*;
#(
    parameter int DataSize = 32
) (
    input  logic [DataSize-1:0] i_rdata,
    input  load_size_e          i_size,
    input  logic                i_signed,
    input  logic [1:0]          i_offset,
    output logic [DataSize-1:0] o_data
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    // NOTE: every signal written in always_comb gets a value on every path
    // (defaults first), otherwise synthesis infers a latch.
    always_comb begin
        w_byte = i_rdata[{i_offset, 3'b000} +: 8];
        // Only offsets 0 and 2 are legal for halves; offset[1] picks the lane.
        w_half = i_offset[1] ? i_rdata[16 +: 16] : i_rdata[0 +: 16];
        o_data = i_rdata;

        case (i_size)
            LS_BYTE: o_data = {{(DataSize-8){i_signed & w_byte[7]}}, w_byte};
            LS_HALF: o_data = {{(DataSize-16){i_signed & w_half[15]}}, w_half};
            default: o_data = i_rdata;
        endcase
    end

endmodule

// File: rtl/reg_writeback.sv
// -----------------------------------------------------------------------------
// reg_writeback
//   Writeback stage in front of the register file write port. Accepts one
//   retiring instruction at a time (ALU result or load), waits for load data,
//   extracts/extends the addressed lane and issues a one-cycle registered
//   commit. Misalignment, reserved size and memory timeout are flagged with a
//   one-cycle wb_error pulse and a sticky wb_err_code.
//
//   clock           in   system clock
//   reset           in   synchronous, active-low reset
//   wb_valid        in   retiring instruction present
//   wb_ready        out  high only in IDLE
//   wb_rt_addr      in   destination register
//   wb_alu_result   in   result for non-load instructions
//   wb_is_load      in   instruction is a load
//   wb_load_size    in   00 byte, 01 half, 10 word, 11 reserved
//   wb_load_signed  in   sign-extend sub-word loads
//   wb_byte_offset  in   address[1:0] of the load
//   mem_rdata       in   memory read data
//   mem_rvalid      in   mem_rdata valid this cycle
//   write_reg_addr  out  regfile write index (holds between commits)
//   write_reg_data  out  regfile write data  (holds between commits)
//   do_reg_write    out  one-cycle commit strobe
//   wb_error        out  one-cycle error pulse
//   wb_err_code     out  last error code, held until the next error
// -----------------------------------------------------------------------------
module reg_writeback
    import tinisoc_pkg::*;
#(
    parameter int DataSize      = 32,
    parameter int AddrSize      = 5,
    parameter int TimeoutCycles = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                wb_valid,
    output logic                wb_ready,
    input  logic [AddrSize-1:0] wb_rt_addr,
    input  logic [DataSize-1:0] wb_alu_result,
    input  logic                wb_is_load,
    input  logic [1:0]          wb_load_size,
    input  logic                wb_load_signed,
    input  logic [1:0]          wb_byte_offset,
    input  logic [DataSize-1:0] mem_rdata,
    input  logic                mem_rvalid,
    output logic [AddrSize-1:0] write_reg_addr,
    output logic [DataSize-1:0] write_reg_data,
    output logic                do_reg_write,
    output logic                wb_error,
    output logic [1:0]          wb_err_code
);

    localparam int CntW = (TimeoutCycles > 1) ? $clog2(TimeoutCycles) : 1;
    localparam logic [CntW-1:0] CntLast = CntW'(TimeoutCycles - 1);

    // State and latched instruction fields.
    wb_state_e           r_state;
    logic [AddrSize-1:0] r_rt_addr;
    load_size_e          r_size;
    logic                r_signed;
    logic [1:0]          r_offset;
    logic [CntW-1:0]     r_cnt;

    // Registered outputs.
    logic [AddrSize-1:0] r_wr_addr;
    logic [DataSize-1:0] r_wr_data;
    logic                r_do_write;
    logic                r_error;
    wb_err_e             r_err_code;

    // Next-state / control decisions.
    wb_state_e           w_next_state;
    logic                w_accept;
    logic                w_commit;
    logic [AddrSize-1:0] w_commit_addr;
    logic [DataSize-1:0] w_commit_data;
    logic                w_err;
    wb_err_e             w_err_code;
    logic [CntW-1:0]     w_cnt_next;
    load_size_e          w_in_size;
    logic [DataSize-1:0] w_ext_data;

    assign w_in_size = load_size_e'(wb_load_size);

    load_extract #(
        .DataSize (DataSize)
    ) u_load_extract (
        .i_rdata  (mem_rdata),
        .i_size   (r_size),
        .i_signed (r_signed),
        .i_offset (r_offset),
        .o_data   (w_ext_data)
    );

    always_comb begin
        w_next_state  = r_state;
        w_accept      = 1'b0;
        w_commit      = 1'b0;
        w_commit_addr = r_wr_addr;
        w_commit_data = r_wr_data;
        w_err         = 1'b0;
        w_err_code    = r_err_code;
        w_cnt_next    = r_cnt;

        case (r_state)
            ST_IDLE: begin
                if (wb_valid) begin
                    w_accept = 1'b1;
                    if (!wb_is_load) begin
                        // ALU results go straight to the commit registers.
                        w_next_state  = ST_COMMIT;
                        w_commit      = 1'b1;
                        w_commit_addr = wb_rt_addr;
                        w_commit_data = wb_alu_result;
                    end else if (w_in_size == LS_RSVD) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_SIZE;
                    end else if (is_misaligned(w_in_size, wb_byte_offset)) begin
                        w_err      = 1'b1;
                        w_err_code = ERR_MISALIGN;
                    end else begin
                        w_next_state = ST_WAIT_MEM;
                        w_cnt_next   = '0;
                    end
                end
            end

            ST_WAIT_MEM: begin
                // Data is checked before expiry so a response on the last
                // allowed cycle still commits.
                if (mem_rvalid) begin
                    w_next_state  = ST_COMMIT;
                    w_commit      = 1'b1;
                    w_commit_addr = r_rt_addr;
                    w_commit_data = w_ext_data;
                end else if (r_cnt == CntLast) begin
                    w_next_state = ST_IDLE;
                    w_err        = 1'b1;
                    w_err_code   = ERR_TIMEOUT;
                end else begin
                    w_cnt_next = r_cnt + 1'b1;
                end
            end

            ST_COMMIT: w_next_state = ST_IDLE;

            default:   w_next_state = ST_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (!reset) begin
            r_state    <= ST_IDLE;
            r_rt_addr  <= '0;
            r_size     <= LS_BYTE;
            r_signed   <= 1'b0;
            r_offset   <= '0;
            r_cnt      <= '0;
            r_wr_addr  <= '0;
            r_wr_data  <= '0;
            r_do_write <= 1'b0;
            r_error    <= 1'b0;
            r_err_code <= ERR_NONE;
        end else begin
            r_state    <= w_next_state;
            r_cnt      <= w_cnt_next;
            r_do_write <= w_commit;
            r_error    <= w_err;
            r_err_code <= w_err_code;
            if (w_accept) begin
                r_rt_addr <= wb_rt_addr;
                r_size    <= w_in_size;
                r_signed  <= wb_load_signed;
                r_offset  <= wb_byte_offset;
            end
            // Commit registers only move on a commit so the regfile sees
            // stable addr/data while the strobe is low.
            if (w_commit) begin
                r_wr_addr <= w_commit_addr;
                r_wr_data <= w_commit_data;
            end
        end
    end

    assign wb_ready       = (r_state == ST_IDLE);
    assign write_reg_addr = r_wr_addr;
    assign write_reg_data = r_wr_data;
    assign do_reg_write   = r_do_write;
    assign wb_error       = r_error;
    assign wb_err_code    = r_err_code;

endmodule

// File: tb/tb_reg_writeback.sv
// -----------------------------------------------------------------------------
// tb_reg_writeback
//   Directed bench for reg_writeback. Expected commits and errors are queued
//   from a transaction-level model; a per-cycle monitor matches every strobe
//   against the queues and checks that held outputs stay put.
// -----------------------------------------------------------------------------
module tb_reg_writeback;

    logic        clock;
    logic        reset;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_rt_addr;
    logic [31:0] wb_alu_result;
    logic        wb_is_load;
    logic [1:0]  wb_load_size;
    logic        wb_load_signed;
    logic [1:0]  wb_byte_offset;
    logic [31:0] mem_rdata;
    logic        mem_rvalid;
    logic [4:0]  write_reg_addr;
    logic [31:0] write_reg_data;
    logic        do_reg_write;
    logic        wb_error;
    logic [1:0]  wb_err_code;

    reg_writeback #(
        .DataSize      (32),
        .AddrSize      (5),
        .TimeoutCycles (16)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .wb_valid       (wb_valid),
        .wb_ready       (wb_ready),
        .wb_rt_addr     (wb_rt_addr),
        .wb_alu_result  (wb_alu_result),
        .wb_is_load     (wb_is_load),
        .wb_load_size   (wb_load_size),
        .wb_load_signed (wb_load_signed),
        .wb_byte_offset (wb_byte_offset),
        .mem_rdata      (mem_rdata),
        .mem_rvalid     (mem_rvalid),
        .write_reg_addr (write_reg_addr),
        .write_reg_data (write_reg_data),
        .do_reg_write   (do_reg_write),
        .wb_error       (wb_error),
        .wb_err_code    (wb_err_code)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)",
                     name, act, exp, $time);
        end
    endtask

    // ---------------- model ----------------
    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } commit_t;

    commit_t     exp_commits[$];
    logic [1:0]  exp_errors[$];
    logic [4:0]  m_addr;
    logic [31:0] m_data;
    logic [1:0]  m_code;
    bit          armed = 0;

    // Value a load must produce: shift the addressed byte down, mask to the
    // access size, and add the sign fill as an arithmetic offset.
    function automatic logic [31:0] model_load(input logic [31:0] rd,
                                               input int size, input bit sgn,
                                               input int off);
        logic [31:0] v;
        v = rd >> (8 * off);
        if (size == 0) begin
            v = v & 32'h0000_00FF;
            if (sgn && v >= 32'h80) v = v + 32'hFFFF_FF00;
        end else if (size == 1) begin
            v = v & 32'h0000_FFFF;
            if (sgn && v >= 32'h8000) v = v + 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    // Per-cycle monitor, sampled away from the active edge.
    always @(negedge clock) begin
        if (reset && armed) begin
            if (do_reg_write) begin
                check("commit_expected", 32'(exp_commits.size() != 0), 32'd1);
                if (exp_commits.size() != 0) begin
                    commit_t e;
                    e = exp_commits.pop_front();
                    m_addr = e.addr;
                    m_data = e.data;
                end
            end
            if (wb_error) begin
                check("error_expected", 32'(exp_errors.size() != 0), 32'd1);
                if (exp_errors.size() != 0) m_code = exp_errors.pop_front();
            end
            check("mon_addr", 32'(write_reg_addr), 32'(m_addr));
            check("mon_data", write_reg_data, m_data);
            check("mon_err_code", 32'(wb_err_code), 32'(m_code));
        end
    end

    // ---------------- drivers ----------------
    logic [4:0] cur_rt;
    int         cur_size;
    bit         cur_sgn;
    int         cur_off;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic issue_alu(input logic [4:0] rt, input logic [31:0] val);
        commit_t c;
        check("alu_ready_before", 32'(wb_ready), 32'd1);
        wb_valid = 1'b1; wb_is_load = 1'b0; wb_rt_addr = rt; wb_alu_result = val;
        c.addr = rt; c.data = val;
        exp_commits.push_back(c);
        step();
        wb_valid = 1'b0;
        check("alu_strobe", 32'(do_reg_write), 32'd1);
        check("alu_addr", 32'(write_reg_addr), 32'(rt));
        check("alu_data", write_reg_data, val);
        check("alu_ready_commit", 32'(wb_ready), 32'd0);
        step();
        check("alu_strobe_drop", 32'(do_reg_write), 32'd0);
        check("alu_ready_after", 32'(wb_ready), 32'd1);
    endtask

    task automatic issue_load(input logic [4:0] rt, input int size,
                              input bit sgn, input int off);
        check("ld_ready_before", 32'(wb_ready), 32'd1);
        wb_valid = 1'b1; wb_is_load = 1'b1; wb_rt_addr = rt;
        wb_load_size = 2'(size); wb_load_signed = sgn; wb_byte_offset = 2'(off);
        cur_rt = rt; cur_size = size; cur_sgn = sgn; cur_off = off;
        step();
        wb_valid = 1'b0;
        check("ld_waiting", 32'(wb_ready), 32'd0);
    endtask

    // Present read data for one cycle; exp_lit is the hand-computed result.
    task automatic give_rdata(input logic [31:0] rd, input logic [31:0] exp_lit);
        commit_t c;
        mem_rdata = rd; mem_rvalid = 1'b1;
        c.addr = cur_rt; c.data = model_load(rd, cur_size, cur_sgn, cur_off);
        exp_commits.push_back(c);
        step();
        mem_rvalid = 1'b0;
        check("ld_strobe", 32'(do_reg_write), 32'd1);
        check("ld_addr", 32'(write_reg_addr), 32'(cur_rt));
        check("ld_data_literal", write_reg_data, exp_lit);
        check("ld_no_error", 32'(wb_error), 32'd0);
        step();
        check("ld_strobe_drop", 32'(do_reg_write), 32'd0);
        check("ld_ready_after", 32'(wb_ready), 32'd1);
    endtask

    task automatic issue_load_err(input logic [4:0] rt, input int size,
                                  input bit sgn, input int off,
                                  input logic [1:0] code);
        check("err_ready_before", 32'(wb_ready), 32'd1);
        wb_valid = 1'b1; wb_is_load = 1'b1; wb_rt_addr = rt;
        wb_load_size = 2'(size); wb_load_signed = sgn; wb_byte_offset = 2'(off);
        exp_errors.push_back(code);
        step();
        wb_valid = 1'b0;
        check("err_pulse", 32'(wb_error), 32'd1);
        check("err_code", 32'(wb_err_code), 32'(code));
        check("err_no_write", 32'(do_reg_write), 32'd0);
        check("err_ready", 32'(wb_ready), 32'd1);
        step();
        check("err_pulse_drop", 32'(wb_error), 32'd0);
        check("err_code_hold", 32'(wb_err_code), 32'(code));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b0; wb_valid = 1'b0; wb_rt_addr = '0; wb_alu_result = '0;
        wb_is_load = 1'b0; wb_load_size = '0; wb_load_signed = 1'b0;
        wb_byte_offset = '0; mem_rdata = '0; mem_rvalid = 1'b0;
        m_addr = '0; m_data = '0; m_code = '0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        armed = 1;

        // Reset state.
        check("rst_ready", 32'(wb_ready), 32'd1);
        check("rst_strobe", 32'(do_reg_write), 32'd0);
        check("rst_error", 32'(wb_error), 32'd0);
        check("rst_code", 32'(wb_err_code), 32'd0);
        check("rst_addr", 32'(write_reg_addr), 32'd0);
        check("rst_data", write_reg_data, 32'd0);

        // Stray read data in IDLE is ignored.
        mem_rdata = 32'h5555_5555; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check("idle_rvalid_ignored", 32'(do_reg_write), 32'd0);

        issue_alu(5'd7, 32'hDEAD_BEEF);

        // Signed byte, data three cycles after acceptance; a stray wb_valid
        // while waiting must not be taken.
        issue_load(5'd4, 0, 1'b1, 3);
        step();
        wb_valid = 1'b1; wb_is_load = 1'b0; wb_alu_result = 32'h1111_1111;
        step();
        wb_valid = 1'b0;
        check("busy_valid_ignored", 32'(wb_ready), 32'd0);
        give_rdata(32'h8012_3456, 32'hFFFF_FF80);

        issue_load(5'd12, 1, 1'b0, 2);
        give_rdata(32'h9ABC_0000, 32'h0000_9ABC);
        issue_load(5'd13, 1, 1'b1, 2);
        give_rdata(32'h9ABC_0000, 32'hFFFF_9ABC);
        issue_load(5'd30, 2, 1'b1, 0);
        give_rdata(32'h1234_5678, 32'h1234_5678);
        issue_load(5'd0, 0, 1'b1, 1);
        give_rdata(32'hA5C3_7E01, 32'h0000_007E);
        issue_load(5'd1, 0, 1'b0, 2);
        give_rdata(32'hA5C3_7E01, 32'h0000_00C3);
        issue_load(5'd2, 1, 1'b1, 0);
        give_rdata(32'h0000_8001, 32'hFFFF_8001);

        // Misaligned half; a later rvalid must not produce a write.
        issue_load_err(5'd5, 1, 1'b0, 1, 2'b01);
        mem_rdata = 32'hFFFF_FFFF; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check("misalign_rvalid_ignored", 32'(do_reg_write), 32'd0);
        issue_load_err(5'd6, 2, 1'b0, 2, 2'b01);
        issue_load_err(5'd8, 3, 1'b0, 0, 2'b11);

        // Timeout: 16 WAIT_MEM cycles without data.
        issue_load(5'd9, 2, 1'b0, 0);
        repeat (15) step();
        check("to_still_waiting", 32'(wb_ready), 32'd0);
        check("to_no_early_error", 32'(wb_error), 32'd0);
        exp_errors.push_back(2'b10);
        step();
        check("to_pulse", 32'(wb_error), 32'd1);
        check("to_code", 32'(wb_err_code), 32'd2);
        check("to_no_write", 32'(do_reg_write), 32'd0);
        check("to_ready", 32'(wb_ready), 32'd1);
        step();
        check("to_pulse_drop", 32'(wb_error), 32'd0);

        // Data on the expiry cycle wins.
        issue_load(5'd9, 2, 1'b0, 0);
        repeat (15) step();
        give_rdata(32'hCAFE_F00D, 32'hCAFE_F00D);
        check("to_race_code_hold", 32'(wb_err_code), 32'd2);

        // Reset in WAIT_MEM aborts silently.
        issue_load(5'd10, 2, 1'b0, 0);
        step();
        reset = 1'b0;
        exp_commits.delete();
        exp_errors.delete();
        m_addr = '0; m_data = '0; m_code = '0;
        step();
        reset = 1'b1;
        check("mid_rst_ready", 32'(wb_ready), 32'd1);
        check("mid_rst_strobe", 32'(do_reg_write), 32'd0);
        check("mid_rst_code", 32'(wb_err_code), 32'd0);
        check("mid_rst_data", write_reg_data, 32'd0);
        mem_rdata = 32'h7777_7777; mem_rvalid = 1'b1;
        step();
        mem_rvalid = 1'b0;
        check("mid_rst_rvalid_ignored", 32'(do_reg_write), 32'd0);
        step();

        issue_alu(5'd0, 32'h0BAD_F00D);
        repeat (2) step();

        check("commits_drained", 32'(exp_commits.size()), 32'd0);
        check("errors_drained", 32'(exp_errors.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
